pzcorebus_response_slicer: RTL and testbench
============================================

# pzcorebus_response_slicer

- Register-slice pipeline for the pzcorebus response channel.
- Carries a response beat from a downstream slave (seen on `master_if`) back toward the upstream master (driven on `slave_if`).
- Inserts STAGES of elastic storage with its own per-stage buffering FSMs, so long response routes can be retimed without losing throughput.
- Pairs with the request slicer on the same bus segment; request and response paths are sliced independently.

## Interface
- BUS_CONFIG, '0, pzcorebus configuration; sets packed response width RW = get_packed_response_width(BUS_CONFIG).
- STAGES, 1, number of slice stages. 0 = combinational pass-through.
- FIFO_SLICER, 1, per-stage storage mode:
  - 1 = 2-entry full-bandwidth stage.
  - 0 = 1-entry half-bandwidth stage.
- DISABLE_MBFF, 0, 1 = disable multi-bit flop inference on payload registers.
- i_clk  input  1  clock; single clock domain.
- i_rst  input  1  reset; synchronous, active-high.
- master_if  interface.response_master  —  downstream side.
  - Inputs: sresp_valid and the packed response (sresp, sid, serror, sdata, sinfo, sresp_uniten, sresp_last).
  - Output: mresp_accept.
- slave_if  interface.response_slave  —  upstream side.
  - Outputs: sresp_valid and the packed response.
  - Input: mresp_accept.
- o_busy  output  1  high when any stage holds a beat.
- o_hold_violation  output  1  sticky protocol error flag; present only with the macro, see Configuration.

## Operation
- Payload is handled as one opaque RW-bit vector.
  - Packed from master_if with get_packed_response().
  - Unpacked onto slave_if with put_packed_response().
  - No field is interpreted; sresp_last is carried unchanged.
- Stages are chained: stage k output feeds stage k+1 input. Stage 0 takes master_if; the last stage drives slave_if.
- Full-bandwidth stage (FIFO_SLICER=1):
  - Storage: 2 entries, 1-bit write pointer, 1-bit read pointer, 2-bit count.
  - States: EMPTY(0), HALF(1), FULL(2).
  - in_ready = (count != 2); out_valid = (count != 0); output data = entry[rd_ptr].
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - EMPTY: push → HALF.
  - HALF: push without pop → FULL; pop without push → EMPTY; push and pop together → HALF, both pointers advance.
  - FULL: pop → HALF. No push is possible while FULL.
- Half-bandwidth stage (FIFO_SLICER=0):
  - Storage: 1 entry, 1-bit full flag.
  - in_ready = !full; push sets full; pop clears full.
  - Push and pop cannot occur in the same cycle.
- STAGES=0: all signals wired straight through; o_busy = 0.
- o_busy = OR of all stage occupancy bits. It is registered state, not a function of the input valid.
- Ordering: strict FIFO order end to end. No beat is dropped or duplicated.

## Timing
- Reset, sampled synchronously at a rising edge with i_rst=1:
  - All counts and full flags go to 0; all pointers go to 0.
  - Payload registers are not reset.
- While i_rst=1, master_if.mresp_accept is forced low and slave_if.sresp_valid is forced low.
- First cycle after reset release:
  - mresp_accept = 1, slave_if.sresp_valid = 0, o_busy = 0, o_hold_violation = 0.
- Latency: a beat accepted at edge N is presented on slave_if in cycle N+STAGES, provided the downstream stages are free.
- Throughput:
  - FIFO_SLICER=1: 1 beat/cycle under continuous accept.
  - FIFO_SLICER=0: 1 beat per 2 cycles.
- Backpressure:
  - Stall timing: with slave_if.mresp_accept held low, mresp_accept drops after 2·STAGES beats are captured (FIFO_SLICER=1) or after STAGES beats (FIFO_SLICER=0).
  - Combinational path: mresp_accept depends only on stage 0 state, never combinationally on slave_if.mresp_accept when STAGES≥1.
- Reset asserted mid-burst: all in-flight beats are discarded; there is no partial output.

## Configuration
- Macro: PZCOREBUS_RESPONSE_SLICER_HOLD_CHECK_EN.
- Defined:
  - Adds an input protocol checker on master_if.
  - A register holds the previous cycle's sresp_valid, the previous mresp_accept and the previous payload.
  - Violation: previous cycle had valid=1 and accept=0, and now valid=0 or the payload differs.
  - On a violation, o_hold_violation sets at the next edge and stays set until i_rst.
- Undefined:
  - The checker logic and its registers are absent.
  - o_hold_violation is tied to 0.
  - The datapath is identical in both builds.

## Test plan
- Reset release, STAGES=2, FIFO_SLICER=1, no traffic → mresp_accept=1, slave_if.sresp_valid=0, o_busy=0 on first post-reset cycle.
- Latency and throughput: 8 beats, payload 0x01..0x08, back-to-back, slave_if.mresp_accept=1, STAGES=2 → beat 0x01 appears 2 cycles after its accept; 8 consecutive output cycles in order.
- Full backpressure: slave_if.mresp_accept=0, 6 beats offered, STAGES=2, FIFO_SLICER=1 → exactly 4 beats captured, then mresp_accept=0. Release accept → outputs 1,2,3,4,5,6 in order.
- Half bandwidth: FIFO_SLICER=0, STAGES=1, continuous valid and accept for 10 cycles → 5 beats transferred; mresp_accept alternates 1/0.
- Reset mid-operation: i_rst pulsed for 1 cycle with 3 beats buffered → o_busy=0 and slave_if.sresp_valid=0 next cycle; no stale beat emitted afterwards.
- Hold check, macro defined: master drops sresp_valid while stalled → o_hold_violation=1 one edge later and stays 1 until reset. Same stimulus with macro undefined → o_hold_violation stays 0.

Source files
------------

// File: rtl/pzcorebus_response_slicer_if.sv
// pzcorebus response-channel bundle and the configuration package that sizes it.
// A zero field in the bus configuration selects that field's default width,
// so the all-zero configuration describes a usable 48-bit response.
package pzcorebus_response_slicer_pkg;

    typedef struct packed {
        logic [7:0] id_width;
        logic [7:0] data_width;
        logic [7:0] info_width;
        logic [7:0] uniten_width;
    } pzcorebus_config;

    localparam int RESP_TYPE_WIDTH = 2;

    function automatic int get_id_width(pzcorebus_config cfg);
        return (cfg.id_width == 8'd0) ? 4 : int'(cfg.id_width);
    endfunction

    function automatic int get_data_width(pzcorebus_config cfg);
        return (cfg.data_width == 8'd0) ? 32 : int'(cfg.data_width);
    endfunction

    function automatic int get_info_width(pzcorebus_config cfg);
        return (cfg.info_width == 8'd0) ? 4 : int'(cfg.info_width);
    endfunction

    function automatic int get_uniten_width(pzcorebus_config cfg);
        return (cfg.uniten_width == 8'd0) ? 4 : int'(cfg.uniten_width);
    endfunction

    // sresp + sid + serror + sdata + sinfo + sresp_uniten + sresp_last
    function automatic int get_packed_response_width(pzcorebus_config cfg);
        return RESP_TYPE_WIDTH + get_id_width(cfg) + 1 + get_data_width(cfg)
             + get_info_width(cfg) + get_uniten_width(cfg) + 1;
    endfunction

endpackage

interface pzcorebus_response_slicer_if
    import pzcorebus_response_slicer_pkg::*;
#(
    parameter pzcorebus_config BUS_CONFIG = '0
);
    localparam int ID_WIDTH     = get_id_width(BUS_CONFIG);
    localparam int DATA_WIDTH   = get_data_width(BUS_CONFIG);
    localparam int INFO_WIDTH   = get_info_width(BUS_CONFIG);
    localparam int UNITEN_WIDTH = get_uniten_width(BUS_CONFIG);

    logic                       sresp_valid;
    logic [RESP_TYPE_WIDTH-1:0] sresp;
    logic [ID_WIDTH-1:0]        sid;
    logic                       serror;
    logic [DATA_WIDTH-1:0]      sdata;
    logic [INFO_WIDTH-1:0]      sinfo;
    logic [UNITEN_WIDTH-1:0]    sresp_uniten;
    logic                       sresp_last;
    logic                       mresp_accept;

    // Receiving side of a response: takes the beat, returns accept.
    modport response_master (
        input  sresp_valid, sresp, sid, serror, sdata, sinfo, sresp_uniten, sresp_last,
        output mresp_accept
    );

    // Sending side of a response: presents the beat, receives accept.
    modport response_slave (
        output sresp_valid, sresp, sid, serror, sdata, sinfo, sresp_uniten, sresp_last,
        input  mresp_accept
    );

endinterface

// File: rtl/pzcorebus_response_slicer.sv
// pzcorebus response-channel register slicer.
// STAGES elastic stages between master_if (downstream slave side) and
// slave_if (upstream master side). FIFO_SLICER selects 2-entry full-bandwidth
// or 1-entry half-bandwidth stages. The payload is carried as one opaque vector.
// Optional macro PZCOREBUS_RESPONSE_SLICER_HOLD_CHECK_EN adds a sticky checker
// for beats withdrawn or altered while stalled; without it o_hold_violation is 0.

// Payload storage for one stage; DISABLE_MBFF keeps every bit in its own flop
// process so tools do not merge payload bits into multi-bit cells.
module pzcorebus_response_slicer_store #(
    parameter int RW           = 8,
    parameter int DEPTH        = 2,
    parameter bit DISABLE_MBFF = 1'b0
)(
    input  logic          i_clk,
    input  logic          i_wr_en,
    input  logic          i_wr_idx,
    input  logic [RW-1:0] i_wr_data,
    input  logic          i_rd_idx,
    output logic [RW-1:0] o_rd_data
);
    if (DISABLE_MBFF) begin : g_bitwise
        for (genvar gi = 0; gi < RW; gi++) begin : g_bit
            logic bit_reg [0:DEPTH-1];
            // Per-bit storage write.
            always_ff @(posedge i_clk) begin
                if (i_wr_en) begin
                    bit_reg[i_wr_idx] <= i_wr_data[gi];
                end
            end
            assign o_rd_data[gi] = bit_reg[i_rd_idx];
        end
    end else begin : g_vector
        logic [RW-1:0] entry_reg [0:DEPTH-1];
        // Whole-entry storage write.
        always_ff @(posedge i_clk) begin
            if (i_wr_en) begin
                entry_reg[i_wr_idx] <= i_wr_data;
            end
        end
        assign o_rd_data = entry_reg[i_rd_idx];
    end
endmodule

module pzcorebus_response_slicer
    import pzcorebus_response_slicer_pkg::*;
#(
    parameter pzcorebus_config BUS_CONFIG   = '0,
    parameter int              STAGES       = 1,
    parameter bit              FIFO_SLICER  = 1'b1,
    parameter bit              DISABLE_MBFF = 1'b0
)(
    input  logic                                     i_clk,
    input  logic                                     i_rst,
    pzcorebus_response_slicer_if.response_master     master_if,
    pzcorebus_response_slicer_if.response_slave      slave_if,
    output logic                                     o_busy,
    output logic                                     o_hold_violation
);
    localparam int RW = get_packed_response_width(BUS_CONFIG);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } stage_state_e;

    // Chain position k is the input of stage k; position STAGES is slave_if.
    logic [STAGES:0] chain_valid;
    logic [STAGES:0] chain_ready;
    logic [RW-1:0]   chain_data [0:STAGES];
    logic [STAGES:0] occupied;
    logic [RW-1:0]   in_payload;
    logic            in_accept;

    assign in_payload = {master_if.sresp, master_if.sid, master_if.serror, master_if.sdata,
                         master_if.sinfo, master_if.sresp_uniten, master_if.sresp_last};

    assign chain_valid[0]      = master_if.sresp_valid;
    assign chain_data[0]       = in_payload;
    assign chain_ready[STAGES] = slave_if.mresp_accept;
    assign occupied[0]         = 1'b0;

    // Handshakes are held off on both sides while reset is applied.
    assign in_accept              = chain_ready[0] & ~i_rst;
    assign master_if.mresp_accept = in_accept;
    assign slave_if.sresp_valid   = chain_valid[STAGES] & ~i_rst;
    assign {slave_if.sresp, slave_if.sid, slave_if.serror, slave_if.sdata,
            slave_if.sinfo, slave_if.sresp_uniten, slave_if.sresp_last} = chain_data[STAGES];

    assign o_busy = |occupied;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic          in_valid;
        logic          in_ready;
        logic [RW-1:0] in_data;
        logic          out_valid;
        logic          out_ready;
        logic [RW-1:0] out_data;
        logic          push;
        logic          pop;

        assign in_valid            = chain_valid[gi];
        assign in_data             = chain_data[gi];
        assign out_ready           = chain_ready[gi+1];
        assign chain_ready[gi]     = in_ready;
        assign chain_valid[gi+1]   = out_valid;
        assign chain_data[gi+1]    = out_data;

        if (FIFO_SLICER) begin : g_full
            stage_state_e state_reg, state_next;
            logic         wr_ptr_reg, wr_ptr_next;
            logic         rd_ptr_reg, rd_ptr_next;

            // Occupancy state and ring pointers.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    state_reg  <= EMPTY;
                    wr_ptr_reg <= 1'b0;
                    rd_ptr_reg <= 1'b0;
                end else begin
                    state_reg  <= state_next;
                    wr_ptr_reg <= wr_ptr_next;
                    rd_ptr_reg <= rd_ptr_next;
                end
            end

            // Handshake decode and occupancy transitions; accept never looks at out_ready.
            always_comb begin
                state_next  = state_reg;
                wr_ptr_next = wr_ptr_reg;
                rd_ptr_next = rd_ptr_reg;
                in_ready    = (state_reg != FULL);
                out_valid   = (state_reg != EMPTY);
                push        = in_valid && in_ready;
                pop         = out_valid && out_ready;
                if (push) begin
                    wr_ptr_next = ~wr_ptr_reg;
                end
                if (pop) begin
                    rd_ptr_next = ~rd_ptr_reg;
                end
                case (state_reg)
                    EMPTY: if (push) state_next = HALF;
                    HALF: begin
                        if (push && !pop) begin
                            state_next = FULL;
                        end else if (pop && !push) begin
                            state_next = EMPTY;
                        end
                    end
                    FULL:    if (pop) state_next = HALF;
                    default: state_next = EMPTY;
                endcase
            end

            assign occupied[gi+1] = (state_reg != EMPTY);

            pzcorebus_response_slicer_store #(
                .RW           (RW),
                .DEPTH        (2),
                .DISABLE_MBFF (DISABLE_MBFF)
            ) u_store (
                .i_clk     (i_clk),
                .i_wr_en   (push),
                .i_wr_idx  (wr_ptr_reg),
                .i_wr_data (in_data),
                .i_rd_idx  (rd_ptr_reg),
                .o_rd_data (out_data)
            );
        end else begin : g_half
            logic full_reg, full_next;

            // Single-entry occupancy flag.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    full_reg <= 1'b0;
                end else begin
                    full_reg <= full_next;
                end
            end

            // Fill when empty, drain when full; never both in one cycle.
            always_comb begin
                full_next = full_reg;
                in_ready  = !full_reg;
                out_valid = full_reg;
                push      = in_valid && in_ready;
                pop       = out_valid && out_ready;
                if (push) begin
                    full_next = 1'b1;
                end else if (pop) begin
                    full_next = 1'b0;
                end
            end

            assign occupied[gi+1] = full_reg;

            pzcorebus_response_slicer_store #(
                .RW           (RW),
                .DEPTH        (1),
                .DISABLE_MBFF (DISABLE_MBFF)
            ) u_store (
                .i_clk     (i_clk),
                .i_wr_en   (push),
                .i_wr_idx  (1'b0),
                .i_wr_data (in_data),
                .i_rd_idx  (1'b0),
                .o_rd_data (out_data)
            );
        end
    end

`ifdef PZCOREBUS_RESPONSE_SLICER_HOLD_CHECK_EN
    logic          prev_valid_reg;
    logic          prev_accept_reg;
    logic [RW-1:0] prev_payload_reg;
    logic          hold_violation_reg;

    // Remember last cycle's offer; latch a stalled beat that was withdrawn or changed.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            prev_valid_reg     <= 1'b0;
            prev_accept_reg    <= 1'b0;
            hold_violation_reg <= 1'b0;
        end else begin
            prev_valid_reg  <= master_if.sresp_valid;
            prev_accept_reg <= in_accept;
            if (prev_valid_reg && !prev_accept_reg &&
                (!master_if.sresp_valid || (in_payload != prev_payload_reg))) begin
                hold_violation_reg <= 1'b1;
            end
        end
        prev_payload_reg <= in_payload;
    end

    assign o_hold_violation = hold_violation_reg;
`else
    assign o_hold_violation = 1'b0;
`endif

endmodule

// File: tb/tb_pzcorebus_response_slicer.sv
// Bench for pzcorebus_response_slicer: DUT A (STAGES=2, full bandwidth) and
// DUT B (STAGES=1, half bandwidth). Accepted beats go into a per-DUT queue;
// a negedge monitor pops and compares every beat the DUT hands upstream.
module tb_pzcorebus_response_slicer;
    import pzcorebus_response_slicer_pkg::*;

    localparam pzcorebus_config CFG = '0;
    localparam int RW = get_packed_response_width(CFG);
    localparam int STG_A = 2;
    localparam int STG_B = 1;
`ifdef PZCOREBUS_RESPONSE_SLICER_HOLD_CHECK_EN
    localparam bit EXP_HOLD = 1'b1;
`else
    localparam bit EXP_HOLD = 1'b0;
`endif

    typedef struct {
        logic [RW-1:0] data;
        int            cyc;
        bit            lat;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    logic          in_valid   [2];
    logic [RW-1:0] in_data    [2];
    logic          acc_force  [2];
    logic          rand_acc   [2];
    logic          rand_bit   [2];
    logic          in_accept  [2];
    logic          out_valid  [2];
    logic          out_accept [2];
    logic [RW-1:0] out_data   [2];
    logic          busy       [2];
    logic          hold       [2];
    int            out_count  [2];
    sb_t           q0 [$];
    sb_t           q1 [$];

    pzcorebus_response_slicer_if #(.BUS_CONFIG(CFG)) a_mif ();
    pzcorebus_response_slicer_if #(.BUS_CONFIG(CFG)) a_sif ();
    pzcorebus_response_slicer_if #(.BUS_CONFIG(CFG)) b_mif ();
    pzcorebus_response_slicer_if #(.BUS_CONFIG(CFG)) b_sif ();

    assign a_mif.sresp_valid = in_valid[0];
    assign {a_mif.sresp, a_mif.sid, a_mif.serror, a_mif.sdata, a_mif.sinfo,
            a_mif.sresp_uniten, a_mif.sresp_last} = in_data[0];
    assign a_sif.mresp_accept = out_accept[0];
    assign in_accept[0] = a_mif.mresp_accept;
    assign out_valid[0] = a_sif.sresp_valid;
    assign out_data[0]  = {a_sif.sresp, a_sif.sid, a_sif.serror, a_sif.sdata, a_sif.sinfo,
                           a_sif.sresp_uniten, a_sif.sresp_last};

    assign b_mif.sresp_valid = in_valid[1];
    assign {b_mif.sresp, b_mif.sid, b_mif.serror, b_mif.sdata, b_mif.sinfo,
            b_mif.sresp_uniten, b_mif.sresp_last} = in_data[1];
    assign b_sif.mresp_accept = out_accept[1];
    assign in_accept[1] = b_mif.mresp_accept;
    assign out_valid[1] = b_sif.sresp_valid;
    assign out_data[1]  = {b_sif.sresp, b_sif.sid, b_sif.serror, b_sif.sdata, b_sif.sinfo,
                           b_sif.sresp_uniten, b_sif.sresp_last};

    assign out_accept[0] = rand_acc[0] ? rand_bit[0] : acc_force[0];
    assign out_accept[1] = rand_acc[1] ? rand_bit[1] : acc_force[1];

    pzcorebus_response_slicer #(
        .BUS_CONFIG(CFG), .STAGES(STG_A), .FIFO_SLICER(1'b1), .DISABLE_MBFF(1'b0)
    ) u_dut_a (
        .i_clk(clk), .i_rst(rst), .master_if(a_mif), .slave_if(a_sif),
        .o_busy(busy[0]), .o_hold_violation(hold[0])
    );

    pzcorebus_response_slicer #(
        .BUS_CONFIG(CFG), .STAGES(STG_B), .FIFO_SLICER(1'b0), .DISABLE_MBFF(1'b1)
    ) u_dut_b (
        .i_clk(clk), .i_rst(rst), .master_if(b_mif), .slave_if(b_sif),
        .o_busy(busy[1]), .o_hold_violation(hold[1])
    );

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endfunction

    function automatic int qsize(int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic void sb_push(int d, logic [RW-1:0] data, int c, bit lat);
        sb_t e;
        e.data = data;
        e.cyc  = c;
        e.lat  = lat;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endfunction

    // Random upstream accept pattern for the random phase.
    always @(posedge clk) begin
        #1;
        rand_bit[0] = ($urandom % 4) != 0;
        rand_bit[1] = ($urandom % 2) != 0;
    end

    // Scoreboard monitor: every upstream handshake must match the oldest accepted beat.
    always @(negedge clk) begin
        sb_t e;
        for (int d = 0; d < 2; d++) begin
            if (!rst && out_valid[d] && out_accept[d]) begin
                out_count[d]++;
                $display("t=%0t dut%0d beat 0x%0h", $time, d, out_data[d]);
                if (qsize(d) == 0) begin
                    check($sformatf("dut%0d_unexpected_beat", d), 64'(out_data[d]), 64'hx);
                end else begin
                    if (d == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    check($sformatf("dut%0d_data", d), 64'(out_data[d]), 64'(e.data));
                    if (e.lat) begin
                        check($sformatf("dut%0d_latency", d), 64'(cyc - e.cyc),
                              64'((d == 0) ? STG_A : STG_B));
                    end
                end
            end
        end
    end

    // Offer one beat, holding it for up to max_wait extra cycles; returns at posedge+1.
    task automatic send(input int d, input logic [RW-1:0] data, input int max_wait,
                        input bit lat, output bit ok);
        ok = 1'b0;
        in_valid[d] = 1'b1;
        in_data[d]  = data;
        for (int w = 0; w <= max_wait; w++) begin
            @(negedge clk);
            if (in_accept[d]) begin
                sb_push(d, data, cyc, lat);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
            if (ok) break;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset(input int n);
        in_valid[0] = 1'b0;
        in_valid[1] = 1'b0;
        rst = 1'b1;
        q0.delete();
        q1.delete();
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_drain(input int d, input int max_cycles);
        for (int w = 0; w < max_cycles; w++) begin
            if (qsize(d) == 0) break;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check($sformatf("dut%0d_drain_left", d), 64'(qsize(d)), 64'd0);
        check($sformatf("dut%0d_drain_valid", d), 64'(out_valid[d]), 64'd0);
        check($sformatf("dut%0d_drain_busy", d), 64'(busy[d]), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int captured;
        int cnt;
        int base;
        logic a;
        logic prev;
        logic [7:0] nxt;

        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            in_data[d]   = '0;
            acc_force[d] = 1'b0;
            rand_acc[d]  = 1'b0;
            rand_bit[d]  = 1'b0;
            out_count[d] = 0;
        end

        // Reset behaviour and first cycle after release.
        rst = 1'b1;
        acc_force[0] = 1'b1;
        acc_force[1] = 1'b1;
        in_valid[0]  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d_rst_accept", d), 64'(in_accept[d]), 64'd0);
            check($sformatf("dut%0d_rst_valid", d), 64'(out_valid[d]), 64'd0);
        end
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        acc_force[0] = 1'b0;
        acc_force[1] = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d_post_rst_accept", d), 64'(in_accept[d]), 64'd1);
            check($sformatf("dut%0d_post_rst_valid", d), 64'(out_valid[d]), 64'd0);
            check($sformatf("dut%0d_post_rst_busy", d), 64'(busy[d]), 64'd0);
            check($sformatf("dut%0d_post_rst_hold", d), 64'(hold[d]), 64'd0);
        end
        @(posedge clk);
        #1;

        // Latency and throughput: 8 back-to-back beats with upstream always accepting.
        acc_force[0] = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            send(0, RW'(i), 0, 1'b1, ok);
            check("a_thru_accept", 64'(ok), 64'd1);
        end
        in_valid[0] = 1'b0;
        wait_drain(0, 20);

        // Full backpressure: 4 beats fit in two stages, then accept drops.
        acc_force[0] = 1'b0;
        base = out_count[0];
        captured = 0;
        for (int i = 1; i <= 6; i++) begin
            send(0, RW'(i), 3, 1'b0, ok);
            if (!ok) break;
            captured++;
        end
        check("a_bp_captured", 64'(captured), 64'd4);
        @(negedge clk);
        check("a_bp_accept_low", 64'(in_accept[0]), 64'd0);
        check("a_bp_busy", 64'(busy[0]), 64'd1);
        check("a_bp_no_output", 64'(out_count[0] - base), 64'd0);
        @(posedge clk);
        #1;
        acc_force[0] = 1'b1;
        send(0, RW'(5), 10, 1'b0, ok);
        check("a_bp_resume5", 64'(ok), 64'd1);
        send(0, RW'(6), 10, 1'b0, ok);
        check("a_bp_resume6", 64'(ok), 64'd1);
        in_valid[0] = 1'b0;
        wait_drain(0, 30);
        check("a_bp_out_count", 64'(out_count[0] - base), 64'd6);

        // Half bandwidth: continuous valid and accept, accept alternates.
        acc_force[1] = 1'b1;
        nxt = 8'h10;
        cnt = 0;
        prev = 1'b0;
        in_valid[1] = 1'b1;
        in_data[1]  = RW'(nxt);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            a = in_accept[1];
            if (k > 0) check("b_half_accept_alternates", 64'(a), 64'(!prev));
            prev = a;
            if (a) begin
                sb_push(1, in_data[1], cyc, 1'b0);
                cnt++;
            end
            @(posedge clk);
            #1;
            if (a) begin
                nxt = nxt + 8'd1;
                in_data[1] = RW'(nxt);
            end
        end
        in_valid[1] = 1'b0;
        check("b_half_beats_in_10", 64'(cnt), 64'd5);
        wait_drain(1, 20);

        // Half-bandwidth backpressure: one beat fills the single stage.
        acc_force[1] = 1'b0;
        captured = 0;
        for (int i = 1; i <= 3; i++) begin
            send(1, RW'(8'h40 + i), 3, 1'b0, ok);
            if (!ok) break;
            captured++;
        end
        check("b_bp_captured", 64'(captured), 64'd1);
        acc_force[1] = 1'b1;
        send(1, RW'(8'h42), 10, 1'b0, ok);
        check("b_bp_resume", 64'(ok), 64'd1);
        in_valid[1] = 1'b0;
        wait_drain(1, 20);

        // Reset with 3 beats buffered: everything discarded, nothing stale emitted.
        acc_force[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(0, RW'(8'h80 + i), 3, 1'b0, ok);
            check("a_rstmid_fill", 64'(ok), 64'd1);
        end
        in_valid[0] = 1'b0;
        @(negedge clk);
        check("a_rstmid_busy_before", 64'(busy[0]), 64'd1);
        @(posedge clk);
        #1;
        pulse_reset(1);
        @(negedge clk);
        check("a_rstmid_busy_after", 64'(busy[0]), 64'd0);
        check("a_rstmid_valid_after", 64'(out_valid[0]), 64'd0);
        check("a_rstmid_accept_after", 64'(in_accept[0]), 64'd1);
        @(posedge clk);
        #1;
        acc_force[0] = 1'b1;
        base = out_count[0];
        idle(8);
        check("a_rstmid_no_stale", 64'(out_count[0] - base), 64'd0);

        // Hold check: stall, then withdraw the pending beat.
        acc_force[0] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send(0, RW'(8'hC0 + i), 3, 1'b0, ok);
            if (!ok) break;
        end
        in_valid[0] = 1'b0;
        @(negedge clk);
        check("a_hold_before", 64'(hold[0]), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("a_hold_set", 64'(hold[0]), 64'(EXP_HOLD));
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("a_hold_sticky", 64'(hold[0]), 64'(EXP_HOLD));
        @(posedge clk);
        #1;
        pulse_reset(1);
        @(negedge clk);
        check("a_hold_cleared", 64'(hold[0]), 64'd0);
        @(posedge clk);
        #1;

        // Randomised traffic against the in-order queue model, both DUTs.
        for (int d = 0; d < 2; d++) begin
            rand_acc[d] = 1'b1;
            for (int n = 0; n < 150; n++) begin
                int gap;
                gap = $urandom_range(0, 2);
                if (gap > 0) begin
                    in_valid[d] = 1'b0;
                    idle(gap);
                end
                send(d, RW'({$urandom, $urandom}), 60, 1'b0, ok);
                check($sformatf("dut%0d_rand_accepted", d), 64'(ok), 64'd1);
            end
            in_valid[d]  = 1'b0;
            rand_acc[d]  = 1'b0;
            acc_force[d] = 1'b1;
            wait_drain(d, 100);
        end

        check("b_hold_clean", 64'(hold[1]), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
